// File: rtl/snn_frame_scheduler_if.sv
// ---------------------------------------------------------------------------
// snn_frame_scheduler_if
// Groups the two buses that the frame scheduler sits between:
//   - the frame push handshake from the SPI side
//     (frame_valid / frame_data / frame_ready)
//   - the evaluate bus to the SNN core
//     (snn_enable / snn_input_spikes / snn_output_spikes)
// Modports:
//   slave  : the scheduler's view. It accepts frames, drives the core
//            inputs and reads the core outputs.
//   master : the surrounding system's view. This is the SPI push side
//            together with the core.
// ---------------------------------------------------------------------------
interface snn_frame_scheduler_if #(
   parameter int N_INPUTS  = 24,
   parameter int N_OUTPUTS = 2
);
   logic                 frame_valid;
   logic [N_INPUTS-1:0]  frame_data;
   logic                 frame_ready;
   logic                 snn_enable;
   logic [N_INPUTS-1:0]  snn_input_spikes;
   logic [N_OUTPUTS-1:0] snn_output_spikes;

   modport slave (
      input  frame_valid,
      input  frame_data,
      output frame_ready,
      output snn_enable,
      output snn_input_spikes,
      input  snn_output_spikes
   );

   modport master (
      output frame_valid,
      output frame_data,
      input  frame_ready,
      input  snn_enable,
      input  snn_input_spikes,
      output snn_output_spikes
   );
endinterface

// File: rtl/snn_frame_scheduler.sv
// ---------------------------------------------------------------------------
// snn_frame_scheduler
// Timestep controller in front of the SNN core (system clock domain).
//
// Input-spike frames pushed by the SPI side are buffered in a small FIFO.
// On each accepted timestep tick, one frame is replayed to the core.
// The scheduler pulses the core enable, waits SETTLE cycles, and then
// captures the core output spikes.
// Per-output saturating spike counters and sticky overrun/underrun flags
// are kept for debug readout.
//
// Ports:
//   clk           system clock (only clock)
//   reset         synchronous, active-low reset
//   run           level; ticks are accepted only while high
//   tick          one-cycle timestep strobe
//   bus           frame push handshake + core evaluate bus (slave modport)
//   out_valid     one-cycle pulse when out_spikes has just been captured
//   out_spikes    last captured core output spikes
//   spike_counts  saturating counters; output i at [i*CNT_W +: CNT_W]
//   clear_counts  clears counters and sticky flags
//   fifo_count    number of frames held in the FIFO
//   busy          high whenever the FSM is not idle
//   overrun       sticky: tick arrived while a frame was in flight
//   underrun      sticky: tick was consumed with the FIFO empty
// ---------------------------------------------------------------------------
module snn_frame_scheduler #(
   parameter int N_INPUTS  = 24,
   parameter int N_OUTPUTS = 2,
   parameter int DEPTH     = 8,
   parameter int SETTLE    = 4,
   parameter int CNT_W     = 16
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         run,
   input  logic                         tick,
   snn_frame_scheduler_if.slave         bus,
   output logic                         out_valid,
   output logic [N_OUTPUTS-1:0]         out_spikes,
   output logic [N_OUTPUTS*CNT_W-1:0]   spike_counts,
   input  logic                         clear_counts,
   output logic [$clog2(DEPTH):0]       fifo_count,
   output logic                         busy,
   output logic                         overrun,
   output logic                         underrun
);

   localparam int PTR_W       = $clog2(DEPTH);
   localparam int FCNT_W      = PTR_W + 1;
   localparam int WAIT_W      = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam int WAIT_LAST_I = (SETTLE > 0) ? SETTLE - 1 : 0;

   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_LAST_I);
   localparam logic [FCNT_W-1:0] FIFO_FULL = FCNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ISSUE   = 2'd1,
      WAIT    = 2'd2,
      CAPTURE = 2'd3
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [WAIT_W-1:0]    wait_cnt_q;

   logic [N_INPUTS-1:0]  mem [DEPTH];
   logic [PTR_W-1:0]     rd_ptr_q;
   logic [PTR_W-1:0]     wr_ptr_q;
   logic [FCNT_W-1:0]    count_q;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 push;
   logic                 pop;

   logic                 tick_accept;
   logic                 tick_drop;
   logic                 capture_load;

   logic                 enable_q;
   logic [N_INPUTS-1:0]  input_spikes_q;

   // FIFO status comes from the registered count only, so frame_ready
   // never depends on a same-cycle pop.
   // While reset is low, frame_ready is held at zero.
   assign fifo_full       = (count_q == FIFO_FULL);
   assign fifo_empty      = (count_q == '0);
   assign bus.frame_ready = reset && !fifo_full;
   assign push            = bus.frame_valid && bus.frame_ready;
   assign pop             = tick_accept && !fifo_empty;

   assign bus.snn_enable       = enable_q;
   assign bus.snn_input_spikes = input_spikes_q;
   assign busy                 = (state_q != IDLE);
   assign fifo_count           = count_q;

   // State register and settle counter.
   // The counter is cleared on the enable cycle and then counts up
   // through WAIT until it reaches SETTLE-1.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ISSUE) begin
            wait_cnt_q <= '0;
         end else if (state_q == WAIT) begin
            wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
         end
      end
   end

   // Next-state logic.
   // capture_load marks the edge that enters CAPTURE. Core outputs are
   // sampled on that edge, so out_valid and the new out_spikes are
   // visible during the CAPTURE cycle itself.
   // A tick seen while a frame is in flight is dropped, not queued.
   always_comb begin
      state_d      = state_q;
      tick_accept  = 1'b0;
      tick_drop    = 1'b0;
      capture_load = 1'b0;
      case (state_q)
         IDLE: begin
            if (tick && run) begin
               tick_accept = 1'b1;
               state_d     = ISSUE;
            end
         end
         ISSUE: begin
            if (SETTLE == 0) begin
               capture_load = 1'b1;
               state_d      = CAPTURE;
            end else begin
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (wait_cnt_q == WAIT_LAST) begin
               capture_load = 1'b1;
               state_d      = CAPTURE;
            end
         end
         CAPTURE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if ((state_q != IDLE) && tick && run) begin
         tick_drop = 1'b1;
      end
   end

   // FIFO pointers and occupancy.
   // DEPTH is a power of two, so the pointers wrap naturally.
   // A push and a pop in the same cycle leave the count unchanged.
   always_ff @(posedge clk) begin
      if (!reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + FCNT_W'(1);
            2'b01:   count_q <= count_q - FCNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // FIFO storage.
   // It needs no reset: a flush only rewinds the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr_q] <= bus.frame_data;
      end
   end

   // Core-facing registers and capture.
   // On issue, the frame is latched and held until the next issue.
   // If the FIFO is empty at issue time, an all-zero frame is presented.
   always_ff @(posedge clk) begin
      if (!reset) begin
         enable_q       <= 1'b0;
         input_spikes_q <= '0;
         out_valid      <= 1'b0;
         out_spikes     <= '0;
      end else begin
         enable_q  <= tick_accept;
         out_valid <= capture_load;
         if (tick_accept) begin
            input_spikes_q <= pop ? mem[rd_ptr_q] : '0;
         end
         if (capture_load) begin
            out_spikes <= bus.snn_output_spikes;
         end
      end
   end

   // Debug statistics.
   // clear_counts wins over any event in the same cycle: that increment
   // or flag set is discarded rather than applied after the clear.
   // Each counter stops at all-ones.
   always_ff @(posedge clk) begin
      if (!reset) begin
         spike_counts <= '0;
         overrun      <= 1'b0;
         underrun     <= 1'b0;
      end else if (clear_counts) begin
         spike_counts <= '0;
         overrun      <= 1'b0;
         underrun     <= 1'b0;
      end else begin
         if (tick_drop) begin
            overrun <= 1'b1;
         end
         if (tick_accept && fifo_empty) begin
            underrun <= 1'b1;
         end
         if (capture_load) begin
            for (int i = 0; i < N_OUTPUTS; i++) begin
               if (bus.snn_output_spikes[i] &&
                   (spike_counts[i*CNT_W +: CNT_W] != {CNT_W{1'b1}})) begin
                  spike_counts[i*CNT_W +: CNT_W] <=
                     spike_counts[i*CNT_W +: CNT_W] + CNT_W'(1);
               end
            end
         end
      end
   end

endmodule
